// File: rtl/core8_mem_arbiter.sv
// ---------------------------------------------------------------------------
// core8_mem_arbiter
//
// Round-robin arbiter that shares one single-port on-chip RAM (1-cycle read
// latency) between NUM_MASTERS Avalon-MM masters. At most one access is
// issued per clock. Read data returns on a shared bus and is qualified by a
// one-hot per-master readdatavalid, so masters can pipeline reads.
//
// Optional feature (macro MEM_ARB_LOCK_EN): adds input m_lock. A granted
// master holding m_lock keeps ownership of the RAM until it drops m_lock or
// a 63-cycle lock limit forces release. Without the macro the port and all
// lock logic are absent.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   m_read, m_write     per-master requests
//   m_address           packed word addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_byteenable        packed byte enables,   master i at [i*BE_W +: BE_W]
//   m_writedata         packed write data,     master i at [i*DATA_W +: DATA_W]
//   m_lock              (MEM_ARB_LOCK_EN only) per-master lock request
//   m_waitrequest       low in the cycle master i is accepted
//   m_readdata          shared read data bus
//   m_readdatavalid     one-hot read-data qualifier
//   mem_*               RAM s1 port (clken tied high)
// ---------------------------------------------------------------------------
module core8_mem_arbiter #(
  parameter int NUM_MASTERS = 8,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int BE_W        = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]        m_lock,
`endif
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [BE_W-1:0]               mem_byteenable,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  output logic [DATA_W-1:0]             mem_writedata,
  output logic                          mem_clken,
  input  logic [DATA_W-1:0]             mem_readdata
);

  localparam int                PTR_W = $clog2(NUM_MASTERS);
  localparam logic [PTR_W-1:0]  LAST  = PTR_W'(NUM_MASTERS - 1);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] rd_pend;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       winner;
  logic [PTR_W-1:0]       winner_inc;
  logic                   any_grant;
  logic                   rd_grant;

`ifdef MEM_ARB_LOCK_EN
  logic                   own_valid;
  logic [PTR_W-1:0]       owner;
  logic [5:0]             lock_cnt;
`endif

  assign req = m_read | m_write;

  // First requester found walking ptr, ptr+1, ... modulo NUM_MASTERS.
  // Reset suppresses every grant so no access leaks out during reset.
  always_comb begin : rr_search
    logic found;
    int   idx;
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip an assignment would infer latches.
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
`ifdef MEM_ARB_LOCK_EN
    // A lock owner excludes everyone else, even while it is idle.
    if (own_valid) begin
      found  = req[owner];
      winner = owner;
    end
`endif
    if (found && !reset) grant[winner] = 1'b1;
  end

  assign any_grant  = |grant;
  assign rd_grant   = any_grant & ~m_write[winner];
  assign winner_inc = (winner == LAST) ? '0 : winner + PTR_W'(1);

  // Winner's request is steered to the RAM in the same cycle it is granted.
  assign mem_address    = m_address[winner*ADDR_W +: ADDR_W];
  assign mem_byteenable = m_byteenable[winner*BE_W +: BE_W];
  assign mem_writedata  = m_writedata[winner*DATA_W +: DATA_W];
  assign mem_chipselect = any_grant;
  assign mem_write      = any_grant & m_write[winner];
  assign mem_clken      = 1'b1;

  assign m_waitrequest   = ~grant;
  assign m_readdata      = mem_readdata;
  // A read accepted just before reset must not report data while reset is
  // held, so the registered valid is also masked by reset itself.
  assign m_readdatavalid = reset ? '0 : rd_pend;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      rd_pend <= '0;
`ifdef MEM_ARB_LOCK_EN
      own_valid <= 1'b0;
      owner     <= '0;
      lock_cnt  <= '0;
`endif
    end else begin
      // Write+read in one request is a write: no data is returned.
      rd_pend <= rd_grant ? grant : '0;
`ifdef MEM_ARB_LOCK_EN
      if (own_valid) begin
        // lock_cnt counts owned cycles; the 63rd one forces release.
        if (m_lock[owner] && lock_cnt != 6'd62) begin
          lock_cnt <= lock_cnt + 6'd1;
        end else begin
          own_valid <= 1'b0;
          lock_cnt  <= '0;
          if (m_lock[owner] || any_grant) ptr <= winner_inc;
        end
      end else if (any_grant) begin
        if (m_lock[winner]) begin
          own_valid <= 1'b1;
          owner     <= winner;
          lock_cnt  <= 6'd1;
          ptr       <= winner;
        end else begin
          ptr <= winner_inc;
        end
      end
`else
      if (any_grant) ptr <= winner_inc;
`endif
    end
  end

endmodule

// File: tb/tb_core8_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_core8_mem_arbiter
//
// Directed testbench for core8_mem_arbiter with 8 masters. A small RAM
// model with byte enables and 1-cycle read latency sits on the mem_* port.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Define MEM_ARB_LOCK_EN to also exercise the lock path.
// ---------------------------------------------------------------------------
module tb_core8_mem_arbiter;

  localparam int N  = 8;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      m_read, m_write;
  logic [N*AW-1:0]   m_address;
  logic [N*BW-1:0]   m_byteenable;
  logic [N*DW-1:0]   m_writedata;
`ifdef MEM_ARB_LOCK_EN
  logic [N-1:0]      m_lock;
`endif
  logic [N-1:0]      m_waitrequest;
  logic [DW-1:0]     m_readdata;
  logic [N-1:0]      m_readdatavalid;
  logic [AW-1:0]     mem_address;
  logic [BW-1:0]     mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0]     mem_writedata;
  logic [DW-1:0]     mem_readdata;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM model plus a backdoor write port used to preload contents.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  core8_mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .clk             (clk),
    .reset           (reset),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_writedata     (m_writedata),
`ifdef MEM_ARB_LOCK_EN
    .m_lock          (m_lock),
`endif
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_clken       (mem_clken),
    .mem_readdata    (mem_readdata)
  );

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    next_cycle();
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    m_read = '0; m_write = '0;
    reset = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_read = '1;
    m_write = 8'h04;
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hFF) begin n_fail++; $display("FAIL reset_waitreq: got %h want ff", m_waitrequest); end
    n_checks++;
    if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", mem_chipselect); end
    n_checks++;
    if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", mem_write); end
    n_checks++;
    if (m_readdatavalid !== 8'h00) begin n_fail++; $display("FAIL reset_rdv: got %h want 00", m_readdatavalid); end
    n_checks++;
    if (mem_clken !== 1'b1) begin n_fail++; $display("FAIL reset_clken: got %b want 1", mem_clken); end
    next_cycle();
    m_read = '0; m_write = '0; reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hFF) begin n_fail++; $display("FAIL idle_waitreq: got %h want ff", m_waitrequest); end
    next_cycle();
  endtask

  task automatic test_single_read();
    m_read[3] = 1'b1;
    m_address[3*AW +: AW] = 13'h0010;
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hF7) begin n_fail++; $display("FAIL single_waitreq: got %h want f7", m_waitrequest); end
    n_checks++;
    if (mem_address !== 13'h0010 || mem_chipselect !== 1'b1 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL single_mem: got addr=%h cs=%b wr=%b want 0010/1/0", mem_address, mem_chipselect, mem_write);
    end
    next_cycle();
    m_read = '0;
    @(negedge clk);
    n_checks++;
    if (m_readdatavalid !== 8'h08) begin n_fail++; $display("FAIL single_rdv: got %h want 08", m_readdatavalid); end
    n_checks++;
    if (m_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", m_readdata); end
    next_cycle();
  endtask

  task automatic test_all_read();
    logic [7:0] exp_w, exp_v;
    do_reset();
    for (int i = 0; i < N; i++) m_address[i*AW +: AW] = AW'(13'h0100 + i);
    m_read = '1;
    for (int c = 0; c <= N; c++) begin
      @(negedge clk);
      if (c < N) begin
        exp_w = ~(8'h01 << c);
        n_checks++;
        if (m_waitrequest !== exp_w) begin n_fail++; $display("FAIL all_grant c=%0d: got %h want %h", c, m_waitrequest, exp_w); end
      end
      exp_v = (c > 0) ? (8'h01 << (c - 1)) : 8'h00;
      n_checks++;
      if (m_readdatavalid !== exp_v) begin n_fail++; $display("FAIL all_rdv c=%0d: got %h want %h", c, m_readdatavalid, exp_v); end
      if (c > 0) begin
        n_checks++;
        if (m_readdata !== 32'hA0000000 + 32'(c - 1)) begin
          n_fail++; $display("FAIL all_data c=%0d: got %h want %h", c, m_readdata, 32'hA0000000 + 32'(c - 1));
        end
      end
      next_cycle();
      if (c < N) m_read[c] = 1'b0;
    end
    // Pointer wrapped to 0: master 0 beats master 7.
    m_read = 8'h81;
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hFE) begin n_fail++; $display("FAIL all_ptr_wrap: got %h want fe", m_waitrequest); end
    next_cycle();
    m_read = '0;
  endtask

  task automatic test_write_read_last();
    m_write[2] = 1'b1;
    m_address[2*AW +: AW] = 13'h1FFF;
    m_byteenable[2*BW +: BW] = 4'b0011;
    m_writedata[2*DW +: DW] = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hFB || mem_write !== 1'b1) begin
      n_fail++; $display("FAIL wr_grant: got wait=%h wr=%b want fb/1", m_waitrequest, mem_write);
    end
    n_checks++;
    if (mem_address !== 13'h1FFF || mem_byteenable !== 4'b0011 || mem_writedata !== 32'h12345678) begin
      n_fail++; $display("FAIL wr_mux: got %h/%b/%h want 1fff/0011/12345678", mem_address, mem_byteenable, mem_writedata);
    end
    next_cycle();
    m_write = '0;
    m_read[2] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hFB || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL rd_after_wr_grant: got wait=%h wr=%b want fb/0", m_waitrequest, mem_write);
    end
    n_checks++;
    if (m_readdatavalid !== 8'h00) begin n_fail++; $display("FAIL wr_no_rdv: got %h want 00", m_readdatavalid); end
    next_cycle();
    m_read = '0;
    @(negedge clk);
    n_checks++;
    if (m_readdatavalid !== 8'h04 || m_readdata !== 32'h00005678) begin
      n_fail++; $display("FAIL rd_after_wr_data: got rdv=%h data=%h want 04/00005678", m_readdatavalid, m_readdata);
    end
    next_cycle();
    // Read and write together act as a write with no data return.
    m_read[5] = 1'b1; m_write[5] = 1'b1;
    m_address[5*AW +: AW] = 13'h0020;
    m_byteenable[5*BW +: BW] = 4'hF;
    m_writedata[5*DW +: DW] = 32'hCAFEF00D;
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hDF || mem_write !== 1'b1) begin
      n_fail++; $display("FAIL rw_as_write: got wait=%h wr=%b want df/1", m_waitrequest, mem_write);
    end
    next_cycle();
    m_read = '0; m_write = '0;
    @(negedge clk);
    n_checks++;
    if (m_readdatavalid !== 8'h00) begin n_fail++; $display("FAIL rw_no_rdv: got %h want 00", m_readdatavalid); end
    next_cycle();
  endtask

  task automatic test_two_masters();
    logic [7:0] exp_w;
    do_reset();
    m_read[1] = 1'b1;            // moves ptr from 0 to 2
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hFD) begin n_fail++; $display("FAIL rr_setup: got %h want fd", m_waitrequest); end
    next_cycle();
    m_read[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_w = (k % 2 == 0) ? 8'hDF : 8'hFD;
      @(negedge clk);
      n_checks++;
      if (m_waitrequest !== exp_w) begin n_fail++; $display("FAIL rr_alt k=%0d: got %h want %h", k, m_waitrequest, exp_w); end
      next_cycle();
    end
    m_read = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_read[4] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hEF) begin n_fail++; $display("FAIL mid_accept: got %h want ef", m_waitrequest); end
    next_cycle();
    reset = 1'b1;
    m_read = '1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (m_readdatavalid !== 8'h00) begin n_fail++; $display("FAIL mid_rdv k=%0d: got %h want 00", k, m_readdatavalid); end
      n_checks++;
      if (m_waitrequest !== 8'hFF || mem_chipselect !== 1'b0) begin
        n_fail++; $display("FAIL mid_hold k=%0d: got wait=%h cs=%b want ff/0", k, m_waitrequest, mem_chipselect);
      end
      next_cycle();
    end
    reset = 1'b0;
    m_read = 8'h81;
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hFE || m_readdatavalid !== 8'h00) begin
      n_fail++; $display("FAIL mid_after: got wait=%h rdv=%h want fe/00", m_waitrequest, m_readdatavalid);
    end
    next_cycle();
    m_read = '0;
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    m_lock = 8'h40;
    m_read[6] = 1'b1;
    for (int k = 0; k < 63; k++) begin
      @(negedge clk);
      n_checks++;
      if (m_waitrequest !== 8'hBF) begin n_fail++; $display("FAIL lock_hold k=%0d: got %h want bf", k, m_waitrequest); end
      next_cycle();
      m_read[0] = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if (m_waitrequest !== 8'hFE) begin n_fail++; $display("FAIL lock_release: got %h want fe", m_waitrequest); end
    next_cycle();
    m_read = '0; m_lock = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    m_read = '0; m_write = '0;
    m_address = '0; m_byteenable = '1; m_writedata = '0;
`ifdef MEM_ARB_LOCK_EN
    m_lock = '0;
`endif
    next_cycle();
    poke(13'h0010, 32'hDEADBEEF);
    poke(13'h1FFF, 32'h00000000);
    for (int i = 0; i < N; i++) poke(AW'(13'h0100 + i), 32'hA0000000 + 32'(i));
    test_reset();
    test_single_read();
    test_all_read();
    test_write_read_last();
    test_two_masters();
    test_reset_mid();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
